// File: rtl/max_pool_single9.sv
// ============================================================================
//  Module   : max_pool_single9
//  Brief    : Pipelined FP16 max-pool of one 9x9 window (registered binary tree).
//             Optional macro: MAXPOOL_NAN_PROPAGATE_EN (NaN in window -> 16'h7E00).
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module max_pool_single9 #(
    parameter int DATA_WIDTH = 16,
    parameter int InputH     = 9,
    parameter int InputW     = 9
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    input  logic [InputH*InputW*DATA_WIDTH-1:0]  mPoolIn,
    output logic                                 out_valid,
    output logic [DATA_WIDTH-1:0]                mPoolOut
);

    localparam int c_N      = InputH * InputW;
    localparam int c_LEVELS = $clog2(c_N);

    // Element count held at tree level lvl (level 0 is the raw window).
    function automatic int levelSize(input int lvl);
        return (c_N + (1 << lvl) - 1) >> lvl;
    endfunction

    // Sign-magnitude to two's complement: +0 and -0 both map to zero.
    function automatic logic signed [DATA_WIDTH-1:0] orderKey(input logic [DATA_WIDTH-1:0] v);
        logic signed [DATA_WIDTH-1:0] mag;
        mag = $signed({1'b0, v[DATA_WIDTH-2:0]});
        return v[DATA_WIDTH-1] ? -mag : mag;
    endfunction

    // Lower-index operand a is kept unless b is strictly greater.
    function automatic logic [DATA_WIDTH-1:0] pickMax(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        return (orderKey(b) > orderKey(a)) ? b : a;
    endfunction

    logic [DATA_WIDTH-1:0] w_leafData [c_N];
    logic [DATA_WIDTH-1:0] r_nodeData [1:c_LEVELS][c_N];
    logic [c_LEVELS:1]     r_validPipe;
    logic [c_LEVELS-1:0]   w_valid;

    assign w_valid = {r_validPipe[c_LEVELS-1:1], in_valid};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_validPipe <= '0;
        end else begin
            r_validPipe <= {r_validPipe[c_LEVELS-1:1], in_valid};
        end
    end

    generate
        for (genvar k = 0; k < c_N; k++) begin : g_leaf
`ifdef MAXPOOL_NAN_PROPAGATE_EN
            // Canonicalising at the leaves makes 16'h7E00 the largest pattern
            // in the tree, so the ordinary max carries NaN to the output.
            logic [DATA_WIDTH-1:0] w_raw;
            assign w_raw = mPoolIn[k*DATA_WIDTH +: DATA_WIDTH];
            assign w_leafData[k] = ((w_raw[14:10] == 5'h1F) && (w_raw[9:0] != 10'd0))
                                   ? 16'h7E00 : w_raw;
`else
            assign w_leafData[k] = mPoolIn[k*DATA_WIDTH +: DATA_WIDTH];
`endif
        end

        for (genvar l = 1; l <= c_LEVELS; l++) begin : g_level
            localparam int c_SIZE = levelSize(l);
            localparam int c_PREV = levelSize(l - 1);

            for (genvar j = 0; j < c_SIZE; j++) begin : g_node
                logic [DATA_WIDTH-1:0] w_left;
                logic [DATA_WIDTH-1:0] w_next;

                if (l == 1) begin : g_fromLeaf
                    assign w_left = w_leafData[2*j];
                    if (2*j + 1 < c_PREV) begin : g_pair
                        assign w_next = pickMax(w_left, w_leafData[2*j+1]);
                    end else begin : g_pass
                        assign w_next = w_left;
                    end
                end else begin : g_fromNode
                    assign w_left = r_nodeData[l-1][2*j];
                    if (2*j + 1 < c_PREV) begin : g_pair
                        assign w_next = pickMax(w_left, r_nodeData[l-1][2*j+1]);
                    end else begin : g_pass
                        assign w_next = w_left;
                    end
                end

                // Data only advances with a valid window, so the output holds between results.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_nodeData[l][j] <= '0;
                    end else if (w_valid[l-1]) begin
                        r_nodeData[l][j] <= w_next;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = r_validPipe[c_LEVELS];
    assign mPoolOut  = r_nodeData[c_LEVELS][0];

endmodule

`default_nettype wire

// File: tb/tb_max_pool_single9.sv
// ============================================================================
//  Module   : tb_max_pool_single9
//  Brief    : Scoreboard bench for max_pool_single9 with directed FP16 windows.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_max_pool_single9;

    localparam int DW  = 16;
    localparam int N   = 81;
    localparam int LAT = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [N*DW-1:0] mPoolIn;
    logic          out_valid;
    logic [DW-1:0] mPoolOut;

    max_pool_single9 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .mPoolIn   (mPoolIn),
        .out_valid (out_valid),
        .mPoolOut  (mPoolOut)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t monE;
    logic [N*DW-1:0] win;

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int k = 0; k < N; k++) win[k*DW +: DW] = v;
    endtask

    task automatic setElem(input int k, input logic [15:0] v);
        win[k*DW +: DW] = v;
    endtask

    task automatic issue(input string name, input logic [15:0] expv);
        exp_t e;
        @(posedge clk);
        #1;
        mPoolIn  = win;
        in_valid = 1'b1;
        e.val  = expv;
        e.cyc  = cyc;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        checkInt("drain_pending", q.size(), 0);
        q.delete();
        repeat (2) @(posedge clk);
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got mPoolOut %h, required no out_valid", mPoolOut);
            end else begin
                monE = q.pop_front();
                checkVal(monE.name, mPoolOut, monE.val);
                checkInt({monE.name, "_latency"}, cyc - monE.cyc, LAT);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        mPoolIn  = '0;
        win      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkInt("reset_out_valid", int'(out_valid), 0);
        checkVal("reset_mPoolOut", mPoolOut, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Mixed positives: 5.0 at the centre
        fill(16'h4000);
        setElem(3, 16'h4200); setElem(17, 16'h4200); setElem(60, 16'h4200);
        setElem(40, 16'h4500);
        issue("case1_mixed_pos", 16'h4500);
        idle();
        drain();

        // All negative, -1.0 at the last index
        fill(16'hC000);
        setElem(80, 16'hBC00);
        issue("case2_all_neg", 16'hBC00);
        idle();
        drain();

        // Signed zero ties keep the lower index
        fill(16'h0000);
        setElem(0, 16'h8000);
        issue("case3_negzero_first", 16'h8000);
        fill(16'h0000);
        setElem(1, 16'h8000);
        issue("case3_poszero_first", 16'h0000);
        idle();
        drain();

        // Back-to-back windows
        fill(16'h3800);
        setElem(5, 16'h3C00);
        issue("case4_win0", 16'h3C00);
        fill(16'h4000);
        setElem(80, 16'h4400);
        issue("case4_win1", 16'h4400);
        fill(16'hFC00);
        issue("case4_win2", 16'hFC00);
        idle();
        drain();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkVal("hold_mPoolOut", mPoolOut, 16'hFC00);
        checkInt("hold_out_valid", int'(out_valid), 0);

        // Subnormals against a zero
        fill(16'h8001);
        setElem(20, 16'h0001);
        setElem(21, 16'h0000);
        issue("subnormal", 16'h0001);
        idle();
        drain();

        // Reset three cycles after acceptance discards the window
        fill(16'h4000);
        setElem(7, 16'h4800);
        issue("case5_discarded", 16'h4800);
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        @(negedge clk);
        checkInt("case5_rst_out_valid", int'(out_valid), 0);
        checkVal("case5_rst_mPoolOut", mPoolOut, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        checkInt("case5_after_out_valid", int'(out_valid), 0);
        checkVal("case5_after_mPoolOut", mPoolOut, 16'h0000);

        // Infinity and NaN handling
        fill(16'h4000);
        setElem(10, 16'h7C00);
        issue("case6_posinf", 16'h7C00);
        setElem(50, 16'h7D01);
`ifdef MAXPOOL_NAN_PROPAGATE_EN
        issue("case6_posnan", 16'h7E00);
`else
        issue("case6_posnan", 16'h7D01);
`endif
        fill(16'hFC00);
        setElem(30, 16'hFD01);
`ifdef MAXPOOL_NAN_PROPAGATE_EN
        issue("case6_negnan", 16'h7E00);
`else
        issue("case6_negnan", 16'hFC00);
`endif
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
